// File: rtl/hdr_merge_sync_ctrl.sv
`timescale 1ns/1ps
// Frame-level sequencer for the two-exposure HDR merge: aligns both streams on SOP,
// issues joint pixel-pair accepts under output-buffer credits, and regenerates output framing.
module hdr_merge_sync_ctrl #(
    parameter int LATENCY = 20,
    parameter int CREDITS = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             snk0_valid_i,
    input  logic             snk0_sop_i,
    input  logic             snk0_eop_i,
    output logic             snk0_ready_o,
    input  logic             snk1_valid_i,
    input  logic             snk1_sop_i,
    input  logic             snk1_eop_i,
    output logic             snk1_ready_o,
    input  logic             credit_ret_i,
    output logic             pair_acc_o,
    output logic             src_valid_o,
    output logic             src_sop_o,
    output logic             src_eop_o,
    output logic             src_error_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic             err_sticky_o,
    input  logic             err_clr_i
);

    localparam int CR_W  = $clog2(CREDITS + 1);
    localparam int AGE_W = $clog2(LATENCY + 2);
    localparam logic [CR_W-1:0]  CR_FULL  = CR_W'(CREDITS);
    localparam logic [AGE_W-1:0] AGE_NONE = AGE_W'(LATENCY + 1);

    // state  | meaning
    // IDLE   | stopped, both readies low, waiting for enable_i
    // SEEK   | drop non-SOP beats, hold each stream at its SOP until both are held
    // STREAM | joint accept of pixel pairs until EOP or a misalignment fault
    typedef enum logic [1:0] {IDLE, SEEK, STREAM} state_t;

    state_t           state;
    logic             held0;
    logic             held1;
    logic             first_beat;
    logic [CR_W-1:0]  credits;
    logic [AGE_W-1:0] last_age;
    logic [3:0]       tag_pipe [1:LATENCY];

    logic             has_credit;
    logic             sop0;
    logic             sop1;
    logic             fault;
    logic             accept;
    logic             drop0;
    logic             drop1;
    logic             go_stream;
    logic             eop_both;
    logic             eop_one;
    logic [CNT_W:0]   drop_sum;

    assign has_credit = (credits != '0);
    assign sop0       = snk0_valid_i & snk0_sop_i;
    assign sop1       = snk1_valid_i & snk1_sop_i;
    assign fault      = (state == STREAM) & ~first_beat & (sop0 | sop1);
    assign accept     = (state == STREAM) & snk0_valid_i & snk1_valid_i & has_credit & ~fault;
    assign drop0      = (state == SEEK) & ~held0 & snk0_valid_i & ~snk0_sop_i;
    assign drop1      = (state == SEEK) & ~held1 & snk1_valid_i & ~snk1_sop_i;
    assign go_stream  = (state == SEEK) & (held0 | sop0) & (held1 | sop1) & has_credit;
    assign eop_both   = accept & snk0_eop_i & snk1_eop_i;
    assign eop_one    = accept & (snk0_eop_i ^ snk1_eop_i);
    assign drop_sum   = {1'b0, drop_cnt_o} + {{CNT_W{1'b0}}, drop0} + {{CNT_W{1'b0}}, drop1};

    assign snk0_ready_o = accept | drop0;
    assign snk1_ready_o = accept | drop1;
    assign pair_acc_o   = accept;
    assign {src_valid_o, src_sop_o, src_eop_o, src_error_o} = tag_pipe[LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            held0        <= 1'b0;
            held1        <= 1'b0;
            first_beat   <= 1'b0;
            frame_cnt_o  <= '0;
            err_sticky_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i) state <= SEEK;
                end
                SEEK: begin
                    if (go_stream) begin
                        state      <= STREAM;
                        first_beat <= 1'b1;
                        held0      <= 1'b0;
                        held1      <= 1'b0;
                    end else begin
                        held0 <= held0 | sop0;
                        held1 <= held1 | sop1;
                    end
                end
                STREAM: begin
                    if (accept) first_beat <= 1'b0;
                    if (eop_both) begin
                        if (frame_cnt_o != '1) frame_cnt_o <= frame_cnt_o + CNT_W'(1);
                        state <= enable_i ? SEEK : IDLE;
                    end else if (eop_one || fault) begin
                        state <= SEEK;
                    end
                end
                default: state <= IDLE;
            endcase
            if (eop_one || fault) err_sticky_o <= 1'b1;
            else if (err_clr_i)   err_sticky_o <= 1'b0;
        end
    end

    // last_age tracks which tag stage holds the most recently accepted beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits    <= CR_FULL;
            drop_cnt_o <= '0;
            last_age   <= AGE_NONE;
        end else begin
            if (accept && !credit_ret_i)
                credits <= credits - CR_W'(1);
            else if (!accept && credit_ret_i && credits != CR_FULL)
                credits <= credits + CR_W'(1);
            drop_cnt_o <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            if (accept)
                last_age <= AGE_W'(1);
            else if (last_age != AGE_NONE)
                last_age <= last_age + AGE_W'(1);
        end
    end

    // A fault closes the truncated frame by marking its last beat eop+error in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i <= LATENCY; i++) tag_pipe[i] <= 4'b0000;
        end else begin
            tag_pipe[1] <= {accept, accept & first_beat, eop_both | eop_one, eop_one};
            for (int i = 2; i <= LATENCY; i++)
                tag_pipe[i] <= tag_pipe[i-1] |
                               ((fault && last_age == AGE_W'(i - 1)) ? 4'b0011 : 4'b0000);
        end
    end

endmodule

// File: tb/tb_hdr_merge_sync_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for hdr_merge_sync_ctrl: directed exposure streams, expected merged
// beat tags queued by the stimulus and compared by an independent output monitor.
module tb_hdr_merge_sync_ctrl;
    localparam int LATENCY = 20;
    localparam int CREDITS = 32;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable_i;
    logic             snk0_valid_i, snk0_sop_i, snk0_eop_i, snk0_ready_o;
    logic             snk1_valid_i, snk1_sop_i, snk1_eop_i, snk1_ready_o;
    logic             credit_ret_i;
    logic             pair_acc_o;
    logic             src_valid_o, src_sop_o, src_eop_o, src_error_o;
    logic [CNT_W-1:0] frame_cnt_o, drop_cnt_o;
    logic             err_sticky_o;
    logic             err_clr_i;

    hdr_merge_sync_ctrl #(.LATENCY(LATENCY), .CREDITS(CREDITS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i),
        .snk0_valid_i(snk0_valid_i), .snk0_sop_i(snk0_sop_i), .snk0_eop_i(snk0_eop_i),
        .snk0_ready_o(snk0_ready_o),
        .snk1_valid_i(snk1_valid_i), .snk1_sop_i(snk1_sop_i), .snk1_eop_i(snk1_eop_i),
        .snk1_ready_o(snk1_ready_o),
        .credit_ret_i(credit_ret_i), .pair_acc_o(pair_acc_o),
        .src_valid_o(src_valid_o), .src_sop_o(src_sop_o), .src_eop_o(src_eop_o),
        .src_error_o(src_error_o),
        .frame_cnt_o(frame_cnt_o), .drop_cnt_o(drop_cnt_o),
        .err_sticky_o(err_sticky_o), .err_clr_i(err_clr_i)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic v; logic sop; logic eop; } beat_t;
    typedef struct packed { logic sop; logic eop; logic err; } tag_t;

    beat_t q0[$];
    beat_t q1[$];
    tag_t  exp_q[$];
    int    acc_t[$];
    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;
    int    n_acc = 0;
    int    run = 0;
    int    max_run = 0;
    int    stall0 = 0;
    logic  shown0 = 1'b0;
    logic  shown1 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive();
        shown0       = q0.size() > 0;
        shown1       = q1.size() > 0;
        snk0_valid_i = shown0 ? q0[0].v : 1'b0;
        snk0_sop_i   = shown0 ? q0[0].sop : 1'b0;
        snk0_eop_i   = shown0 ? q0[0].eop : 1'b0;
        snk1_valid_i = shown1 ? q1[0].v : 1'b0;
        snk1_sop_i   = shown1 ? q1[0].sop : 1'b0;
        snk1_eop_i   = shown1 ? q1[0].eop : 1'b0;
    endtask

    task automatic add(input int s, input logic v, input logic sop, input logic eop);
        beat_t b;
        b = {v, sop, eop};
        if (s == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    task automatic frame(input int s, input int len);
        for (int i = 0; i < len; i++) add(s, 1'b1, i == 0, i == len - 1);
    endtask

    task automatic exp_tag(input logic sop, input logic eop, input logic err);
        exp_q.push_back({sop, eop, err});
    endtask

    task automatic expect_frame(input int len);
        for (int i = 0; i < len; i++) exp_tag(i == 0, i == len - 1, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((q0.size() > 0 || q1.size() > 0) && k < 400) begin
            step();
            k++;
        end
        check({name, "_queues_empty"}, q0.size() + q1.size(), 0);
        repeat (LATENCY + 4) step();
        check({name, "_scoreboard_empty"}, exp_q.size(), 0);
    endtask

    // Stream driver: a beat leaves its queue once handshaken; idle entries last one cycle
    initial begin
        logic a0, a1;
        forever begin
            @(negedge clk);
            a0 = shown0 && (!snk0_valid_i || snk0_ready_o);
            a1 = shown1 && (!snk1_valid_i || snk1_ready_o);
            if (pair_acc_o) begin
                acc_t.push_back(cyc);
                n_acc++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (snk0_valid_i && !snk0_ready_o) stall0++;
            @(posedge clk);
            #1;
            if (a0 && q0.size() > 0) void'(q0.pop_front());
            if (a1 && q1.size() > 0) void'(q1.pop_front());
            drive();
        end
    end

    // Output monitor
    initial begin
        tag_t e;
        int   t;
        forever begin
            @(negedge clk);
            if (src_valid_o) begin
                check("src_beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("src_sop_eop_err", {src_sop_o, src_eop_o, src_error_o}, e);
                end
                check("src_accept_known", acc_t.size() > 0, 1);
                if (acc_t.size() > 0) begin
                    t = acc_t.pop_front();
                    check("src_latency", cyc - t, LATENCY);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected summary before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, k, cnt;
        rst = 1'b1; enable_i = 1'b1; credit_ret_i = 1'b1; err_clr_i = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        check("rst_ready0", snk0_ready_o, 0);
        check("rst_ready1", snk1_ready_o, 0);
        check("rst_pair_acc", pair_acc_o, 0);
        check("rst_src_valid", src_valid_o, 0);
        check("rst_frame_cnt", frame_cnt_o, 0);
        check("rst_drop_cnt", drop_cnt_o, 0);
        check("rst_err_sticky", err_sticky_o, 0);

        // aligned 4-beat frames
        base = n_acc; max_run = 0;
        frame(0, 4); frame(1, 4); expect_frame(4);
        wait_drain("aligned");
        check("aligned_accepts", n_acc - base, 4);
        check("aligned_consecutive", max_run, 4);
        check("aligned_frame_cnt", frame_cnt_o, 1);

        // stream 1 starts with 3 stray beats, stream 0 SOP 5 cycles ahead
        base = n_acc; stall0 = 0;
        frame(0, 4);
        add(1, 1'b0, 1'b0, 1'b0); add(1, 1'b0, 1'b0, 1'b0);
        repeat (3) add(1, 1'b1, 1'b0, 1'b0);
        frame(1, 4); expect_frame(4);
        wait_drain("skew");
        check("skew_drop_cnt", drop_cnt_o, 3);
        check("skew_stream0_held_cycles", stall0, 6);
        check("skew_accepts", n_acc - base, 4);
        check("skew_frame_cnt", frame_cnt_o, 2);

        // credit starvation
        credit_ret_i = 1'b0; base = n_acc;
        frame(0, 40); frame(1, 40); expect_frame(40);
        k = 0;
        while (n_acc - base < 32 && k < 300) begin step(); k++; end
        repeat (30) step();
        check("starve_accepts", n_acc - base, 32);
        check("starve_ready0", snk0_ready_o, 0);
        check("starve_ready1", snk1_ready_o, 0);
        for (int p = 0; p < 3; p++) begin
            credit_ret_i = 1'b1;
            step();
            credit_ret_i = 1'b0;
            repeat (3) step();
        end
        check("credit_pulse_accepts", n_acc - base, 35);
        credit_ret_i = 1'b1;
        wait_drain("starve");
        check("starve_total_accepts", n_acc - base, 40);
        check("starve_frame_cnt", frame_cnt_o, 3);

        // EOP on stream 0 at beat 5, stream 1 at beat 7
        base = n_acc;
        frame(0, 5); frame(0, 4);
        frame(1, 7); frame(1, 4);
        exp_tag(1, 0, 0); exp_tag(0, 0, 0); exp_tag(0, 0, 0); exp_tag(0, 0, 0); exp_tag(0, 1, 1);
        expect_frame(4);
        wait_drain("single_eop");
        check("single_eop_drop_cnt", drop_cnt_o, 5);
        check("single_eop_accepts", n_acc - base, 9);
        check("single_eop_frame_cnt", frame_cnt_o, 4);
        check("single_eop_err_sticky", err_sticky_o, 1);
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        check("err_clr", err_sticky_o, 0);

        // stream 1 restarts with SOP on beat 3
        base = n_acc;
        frame(0, 4); frame(0, 4);
        add(1, 1'b1, 1'b1, 1'b0); add(1, 1'b1, 1'b0, 1'b0); frame(1, 4);
        exp_tag(1, 0, 0); exp_tag(0, 1, 1); expect_frame(4);
        wait_drain("mid_sop");
        check("mid_sop_accepts", n_acc - base, 6);
        check("mid_sop_drop_cnt", drop_cnt_o, 7);
        check("mid_sop_frame_cnt", frame_cnt_o, 5);
        check("mid_sop_err_sticky", err_sticky_o, 1);

        // reset on beat 10 of a 20-beat frame
        base = n_acc;
        frame(0, 20); frame(1, 20);
        k = 0;
        while (n_acc - base < 9 && k < 100) begin step(); k++; end
        check("pre_reset_accepts", n_acc - base, 9);
        rst = 1'b1;
        q0.delete(); q1.delete(); acc_t.delete();
        drive();
        #1;
        check("mid_rst_ready0", snk0_ready_o, 0);
        check("mid_rst_ready1", snk1_ready_o, 0);
        check("mid_rst_pair_acc", pair_acc_o, 0);
        check("mid_rst_src", {src_valid_o, src_sop_o, src_eop_o, src_error_o}, 0);
        check("mid_rst_frame_cnt", frame_cnt_o, 0);
        check("mid_rst_drop_cnt", drop_cnt_o, 0);
        check("mid_rst_err_sticky", err_sticky_o, 0);
        repeat (2) step();
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < LATENCY + 5; c++) begin
            @(negedge clk);
            if (src_valid_o) cnt++;
        end
        check("post_reset_src_valid", cnt, 0);
        step();

        // enable dropped mid-frame: frame completes, then IDLE
        base = n_acc;
        frame(0, 6); frame(1, 6); expect_frame(6);
        k = 0;
        while (n_acc - base < 2 && k < 50) begin step(); k++; end
        enable_i = 1'b0;
        wait_drain("enable_drop");
        check("enable_drop_accepts", n_acc - base, 6);
        check("enable_drop_frame_cnt", frame_cnt_o, 1);
        frame(0, 4); frame(1, 4); expect_frame(4);
        repeat (10) step();
        check("idle_no_accepts", n_acc - base, 6);
        check("idle_ready0", snk0_ready_o, 0);
        enable_i = 1'b1;
        wait_drain("reenable");
        check("reenable_accepts", n_acc - base, 10);
        check("reenable_frame_cnt", frame_cnt_o, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
